// File: rtl/multiplexador_arbitrado_if.sv
// multiplexador_arbitrado_if: channel inputs, selection controls and output handshake of the arbitrated mux
interface multiplexador_arbitrado_if #(
  parameter int LARGURA = 16,
  parameter int CANAIS = 4,
  parameter int SEL_W = 2
);
  logic [CANAIS*LARGURA-1:0] entradas;
  logic [CANAIS-1:0] valido_entrada;
  logic [CANAIS-1:0] pronto_entrada;
  logic modo;
  logic [SEL_W-1:0] M;
  logic [LARGURA-1:0] resultado;
  logic [SEL_W-1:0] canal_saida;
  logic valido_saida;
  logic pronto_saida;
  modport master (
    output entradas, valido_entrada, modo, M, pronto_saida,
    input pronto_entrada, resultado, canal_saida, valido_saida
  );
  modport slave (
    input entradas, valido_entrada, modo, M, pronto_saida,
    output pronto_entrada, resultado, canal_saida, valido_saida
  );
endinterface

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado: N-to-1 registered mux, fixed select or round-robin, valid/ready on every port
module multiplexador_arbitrado #(
  parameter int LARGURA = 16,
  parameter int CANAIS = 4,
  parameter int SEL_W = 2
) (
  input logic clock,
  input logic reset,
  multiplexador_arbitrado_if.slave bus
);
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic [SEL_W-1:0] canal_q, canal_d, ponteiro_q, ponteiro_d, c, idx;
  logic valido_q, valido_d, livre, tem, grant;
  assign livre = !valido_q || bus.pronto_saida;
  // descending scan so the channel closest to ponteiro wins
  always_comb begin
    tem = 1'b0;
    c = '0;
    idx = '0;
    if (!bus.modo) begin
      tem = (int'(bus.M) < CANAIS) && bus.valido_entrada[bus.M];
      c = bus.M;
    end else begin
      for (int k = CANAIS - 1; k >= 0; k--) begin
        idx = SEL_W'((int'(ponteiro_q) + k) % CANAIS);
        if (bus.valido_entrada[idx]) begin
          tem = 1'b1;
          c = idx;
        end
      end
    end
  end
  assign grant = livre && tem && !reset;
  assign bus.pronto_entrada = grant ? CANAIS'(1) << c : '0;
  always_comb begin
    resultado_d = grant ? bus.entradas[int'(c)*LARGURA +: LARGURA] : resultado_q;
    canal_d = grant ? c : canal_q;
    ponteiro_d = !grant ? ponteiro_q : (int'(c) == CANAIS - 1) ? '0 : c + 1'b1;
    valido_d = livre ? tem : valido_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resultado_q <= '0;
      canal_q <= '0;
      ponteiro_q <= '0;
      valido_q <= 1'b0;
    end else begin
      resultado_q <= resultado_d;
      canal_q <= canal_d;
      ponteiro_q <= ponteiro_d;
      valido_q <= valido_d;
    end
  end
  assign bus.resultado = resultado_q;
  assign bus.canal_saida = canal_q;
  assign bus.valido_saida = valido_q;
endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// tb_multiplexador_arbitrado: random and directed stimulus against a behavioural model, 4- and 3-channel instances
module tb_multiplexador_arbitrado;
  logic clock = 0, reset = 1;
  logic modo = 0, ps = 1;
  logic [1:0] M = 0;
  logic [3:0] va = 0;
  logic [2:0] vb = 0;
  logic [63:0] ea = 0;
  logic [47:0] eb = 0;
  int n_chk = 0, n_ok = 0;
  int ptr[2], ch[2];
  logic [15:0] res[2];
  bit v[2];
  multiplexador_arbitrado_if #(.LARGURA(16), .CANAIS(4), .SEL_W(2)) a ();
  multiplexador_arbitrado_if #(.LARGURA(16), .CANAIS(3), .SEL_W(2)) b ();
  multiplexador_arbitrado #(.LARGURA(16), .CANAIS(4), .SEL_W(2)) dut_a (.clock(clock), .reset(reset), .bus(a.slave));
  multiplexador_arbitrado #(.LARGURA(16), .CANAIS(3), .SEL_W(2)) dut_b (.clock(clock), .reset(reset), .bus(b.slave));
  assign a.entradas = ea;
  assign a.valido_entrada = va;
  assign a.modo = modo;
  assign a.M = M;
  assign a.pronto_saida = ps;
  assign b.entradas = eb;
  assign b.valido_entrada = vb;
  assign b.modo = modo;
  assign b.M = M;
  assign b.pronto_saida = ps;
  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(int n, bit md, int m, logic [3:0] val, int p);
    if (!md) return (m < n && val[m]) ? m : -1;
    for (int k = 0; k < n; k++) if (val[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic step(string tag);
    int n, g;
    int gg[2];
    bit lv[2];
    logic [15:0] dd[2];
    logic [3:0] val;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      n = d ? 3 : 4;
      val = d ? {1'b0, vb} : va;
      lv[d] = !v[d] || ps;
      g = lv[d] ? pick(n, modo, int'(M), val, ptr[d]) : -1;
      chk($sformatf("%s.pe%0d", tag, d), d ? 32'(b.pronto_entrada) : 32'(a.pronto_entrada), g < 0 ? 0 : 1 << g);
      chk($sformatf("%s.res%0d", tag, d), d ? 32'(b.resultado) : 32'(a.resultado), 32'(res[d]));
      chk($sformatf("%s.ch%0d", tag, d), d ? 32'(b.canal_saida) : 32'(a.canal_saida), ch[d]);
      chk($sformatf("%s.vld%0d", tag, d), d ? 32'(b.valido_saida) : 32'(a.valido_saida), 32'(v[d]));
      gg[d] = g;
      dd[d] = g < 0 ? 16'h0 : d ? eb[g*16 +: 16] : ea[g*16 +: 16];
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (gg[d] >= 0) begin
        res[d] = dd[d];
        ch[d] = gg[d];
        v[d] = 1;
        ptr[d] = (gg[d] + 1) % (d ? 3 : 4);
      end else if (lv[d]) v[d] = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst.res_a", 32'(a.resultado), 0);
    chk("rst.ch_a", 32'(a.canal_saida), 0);
    chk("rst.vld_a", 32'(a.valido_saida), 0);
    chk("rst.pe_a", 32'(a.pronto_entrada), 0);
    chk("rst.res_b", 32'(b.resultado), 0);
    chk("rst.vld_b", 32'(b.valido_saida), 0);
    chk("rst.pe_b", 32'(b.pronto_entrada), 0);
    va = 0;
    vb = 0;
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0;
      ch[d] = 0;
      res[d] = 0;
      v[d] = 0;
    end
    @(negedge clock) reset = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic rnd_data();
    ea = {$urandom, $urandom};
    eb = {16'($urandom), $urandom};
  endtask

  initial begin
    do_reset();
    // fixed select, channel 2
    modo = 0; M = 2; ps = 1; va = 4'b0100; vb = 3'b100;
    ea = 64'h0000_0002_0000_0000; eb = 48'h0002_0000_0000;
    step("t1");
    chk("t1.res", 32'(a.resultado), 32'h2);
    chk("t1.ch", 32'(a.canal_saida), 2);
    chk("t1.vld", 32'(a.valido_saida), 1);
    M = 1; va = 4'b1101; vb = 3'b101;
    step("t2");
    chk("t2.vld", 32'(a.valido_saida), 0);
    do_reset();
    modo = 1; va = 4'b1111; vb = 3'b111;
    for (int k = 0; k < 5; k++) begin
      rnd_data();
      step("t3");
      chk("t3.ch_a", 32'(a.canal_saida), k % 4);
      chk("t3.ch_b", 32'(b.canal_saida), k % 3);
    end
    va = 4'b1001; vb = 3'b001;
    step("t4a");
    chk("t4.ch3", 32'(a.canal_saida), 3);
    step("t4b");
    chk("t4.ch0", 32'(a.canal_saida), 0);
    va = 4'b1111; vb = 3'b111;
    rnd_data();
    step("t5load");
    ps = 0;
    for (int k = 0; k < 3; k++) begin
      rnd_data();
      step("t5hold");
      chk("t5.hold_ch", 32'(a.canal_saida), 1);
    end
    ps = 1;
    step("t5go");
    chk("t5.next_ch", 32'(a.canal_saida), 2);
    do_reset();
    modo = 0; M = 3; vb = 3'b111; va = 4'b0000;
    step("t6");
    chk("t6.m3_b", 32'(b.valido_saida), 0);
    for (int k = 0; k < 400; k++) begin
      rnd_data();
      modo = 1'($urandom);
      M = 2'($urandom);
      va = 4'($urandom);
      vb = 3'($urandom);
      ps = $urandom_range(0, 3) != 0;
      step("rnd");
    end
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
